irig_sync_ctrl: RTL and testbench

IRIG_SYNC_CTRL -- requirements
Module: irig_sync_ctrl

---
 rtl/irig_sync_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_irig_sync_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/irig_sync_ctrl.sv
// IRIG time-sync controller: acquires lock on decoded IRIG frames, then
// free-runs a local BCD time-of-day with a 1 pps strobe, tolerating
// small phase jitter and bridging short frame outages in holdover.
module irig_sync_ctrl #(
  parameter logic [31:0] CNT_1S = 32'd49_999_999,
  parameter logic [31:0] TOL    = 32'd25_000,
  parameter int unsigned LOCK_N = 3,
  parameter int unsigned HOLD_S = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       time_flag,
  input  logic [6:0] sec_bcd,
  input  logic [6:0] min_bcd,
  input  logic [5:0] hour_bcd,
  output logic       pps,
  output logic [6:0] loc_sec,
  output logic [6:0] loc_min,
  output logic [5:0] loc_hour,
  output logic [1:0] state,
  output logic       locked,
  output logic       time_valid,
  output logic       frame_err
);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'b00,
    ST_ACQUIRE  = 2'b01,
    ST_LOCKED   = 2'b10,
    ST_HOLDOVER = 2'b11
  } state_t;

  // Time words are packed {hour[5:0], min[6:0], sec[6:0]}.
  function automatic logic f_legal(input logic [19:0] t);
    logic ok;
    ok = (t[3:0] <= 4'd9) && (t[6:4] <= 3'd5) &&
         (t[10:7] <= 4'd9) && (t[13:11] <= 3'd5) &&
         (t[17:14] <= 4'd9);
    if (t[19:18] == 2'd3)
      ok = 1'b0;
    else if ((t[19:18] == 2'd2) && (t[17:14] > 4'd3))
      ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [19:0] f_next(input logic [19:0] t);
    logic [3:0] su, mu, hu;
    logic [2:0] st, mt;
    logic [1:0] ht;
    su = t[3:0];   st = t[6:4];
    mu = t[10:7];  mt = t[13:11];
    hu = t[17:14]; ht = t[19:18];
    if (su != 4'd9) su = su + 4'd1;
    else begin
      su = '0;
      if (st != 3'd5) st = st + 3'd1;
      else begin
        st = '0;
        if (mu != 4'd9) mu = mu + 4'd1;
        else begin
          mu = '0;
          if (mt != 3'd5) mt = mt + 3'd1;
          else begin
            mt = '0;
            if ((ht == 2'd2) && (hu == 4'd3)) begin
              ht = '0;
              hu = '0;
            end else if (hu != 4'd9) hu = hu + 4'd1;
            else begin
              hu = '0;
              ht = ht + 2'd1;
            end
          end
        end
      end
    end
    return {ht, hu, mt, mu, st, su};
  endfunction

  state_t      r_state;
  logic [31:0] r_sub_cnt;
  logic [31:0] r_good_cnt;
  logic [31:0] r_hold_cnt;
  logic [19:0] r_prev_t;
  logic [19:0] r_loc;
  logic        r_pps;
  logic        r_frame_err;
  logic        r_after_wrap;  // a wrap occurred since sub_cnt was last re-phased
  logic        r_good_seen;   // a good frame was accepted since the last wrap

  logic [19:0] w_dec;
  logic [19:0] w_dec_next;
  logic [19:0] w_prev_next;
  logic [19:0] w_loc_next;
  logic        w_legal;
  logic        w_wrap;
  logic        w_pre;
  logic        w_post;
  logic        w_acq_good;
  logic        w_lk_pre_good;
  logic        w_lk_post_good;

  assign w_dec       = {hour_bcd, min_bcd, sec_bcd};
  assign w_dec_next  = f_next(w_dec);
  assign w_prev_next = f_next(r_prev_t);
  assign w_loc_next  = f_next(r_loc);
  assign w_legal     = f_legal(w_dec);
  assign w_wrap      = (r_sub_cnt == CNT_1S);
  assign w_pre       = (r_sub_cnt >= (CNT_1S - TOL));
  assign w_post      = r_after_wrap && (r_sub_cnt <= TOL);

  assign w_acq_good = time_flag && w_legal && (w_dec == w_prev_next) &&
                      (w_pre || w_post);
  // Early frame (or one at the wrap) describes the second now ending, so it
  // must match the current local time; a late frame describes the second
  // that ended at the last wrap, so its successor must match local time.
  assign w_lk_pre_good  = time_flag && w_legal && w_pre && (w_dec == r_loc);
  assign w_lk_post_good = time_flag && w_legal && !w_pre && w_post &&
                          (w_dec_next == r_loc);

  assign pps        = r_pps;
  assign frame_err  = r_frame_err;
  assign loc_sec    = r_loc[6:0];
  assign loc_min    = r_loc[13:7];
  assign loc_hour   = r_loc[19:14];
  assign state      = r_state;
  assign locked     = (r_state == ST_LOCKED);
  assign time_valid = (r_state == ST_LOCKED) || (r_state == ST_HOLDOVER);

  // Sync state machine, phase counter, local time and output strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_UNLOCKED;
      r_sub_cnt    <= '0;
      r_good_cnt   <= '0;
      r_hold_cnt   <= '0;
      r_prev_t     <= '0;
      r_loc        <= '0;
      r_pps        <= 1'b0;
      r_frame_err  <= 1'b0;
      r_after_wrap <= 1'b0;
      r_good_seen  <= 1'b0;
    end else begin
      r_pps       <= 1'b0;
      r_frame_err <= 1'b0;
      r_sub_cnt   <= w_wrap ? '0 : r_sub_cnt + 32'd1;
      if (w_wrap) r_after_wrap <= 1'b1;

      case (r_state)
        ST_UNLOCKED: begin
          if (time_flag && w_legal) begin
            r_state      <= ST_ACQUIRE;
            r_good_cnt   <= 32'd1;
            r_prev_t     <= w_dec;
            r_sub_cnt    <= '0;
            r_after_wrap <= 1'b0;
          end
        end

        ST_ACQUIRE: begin
          if (time_flag) begin
            if (w_acq_good) begin
              r_good_cnt   <= r_good_cnt + 32'd1;
              r_prev_t     <= w_dec;
              r_sub_cnt    <= '0;
              r_after_wrap <= 1'b0;
              if ((r_good_cnt + 32'd1) >= LOCK_N) begin
                r_state     <= ST_LOCKED;
                r_loc       <= w_dec_next;
                r_pps       <= 1'b1;
                r_good_seen <= 1'b1;
              end
            end else if (w_legal) begin
              r_good_cnt   <= 32'd1;
              r_prev_t     <= w_dec;
              r_sub_cnt    <= '0;
              r_after_wrap <= 1'b0;
            end else begin
              r_state <= ST_UNLOCKED;
            end
          end else if (r_after_wrap && (r_sub_cnt > TOL)) begin
            r_state <= ST_UNLOCKED;
          end
        end

        default: begin  // ST_LOCKED, ST_HOLDOVER
          if (w_lk_pre_good || w_lk_post_good) begin
            r_state      <= ST_LOCKED;
            r_sub_cnt    <= '0;
            r_after_wrap <= 1'b0;
            r_good_seen  <= 1'b1;
            // The early re-phase pulse stands in for the wrap pulse it preempts.
            if (w_lk_pre_good) begin
              r_pps <= 1'b1;
              r_loc <= w_dec_next;
            end
          end else begin
            if (time_flag) r_frame_err <= 1'b1;
            if (w_wrap) begin
              r_pps       <= 1'b1;
              r_loc       <= w_loc_next;
              r_good_seen <= 1'b0;
              if (r_state == ST_HOLDOVER) r_hold_cnt <= r_hold_cnt + 32'd1;
            end
            if ((r_state == ST_LOCKED) && !w_wrap && (r_sub_cnt == TOL) &&
                !r_good_seen) begin
              r_state    <= ST_HOLDOVER;
              r_hold_cnt <= '0;
            end
            if ((r_state == ST_HOLDOVER) && (r_hold_cnt == HOLD_S))
              r_state <= ST_UNLOCKED;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irig_sync_ctrl.sv
// Scoreboard bench for irig_sync_ctrl with shortened timing parameters.
module tb_irig_sync_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       time_flag;
  logic [6:0] sec_bcd;
  logic [6:0] min_bcd;
  logic [5:0] hour_bcd;
  logic       pps;
  logic [6:0] loc_sec;
  logic [6:0] loc_min;
  logic [5:0] loc_hour;
  logic [1:0] state;
  logic       locked;
  logic       time_valid;
  logic       frame_err;

  irig_sync_ctrl #(
    .CNT_1S(32'd999),
    .TOL   (32'd10),
    .LOCK_N(3),
    .HOLD_S(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .time_flag (time_flag),
    .sec_bcd   (sec_bcd),
    .min_bcd   (min_bcd),
    .hour_bcd  (hour_bcd),
    .pps       (pps),
    .loc_sec   (loc_sec),
    .loc_min   (loc_min),
    .loc_hour  (loc_hour),
    .state     (state),
    .locked    (locked),
    .time_valid(time_valid),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        is_ferr;
    int          cyc;
    logic [19:0] t;
    logic [1:0]  st;
  } ev_t;

  ev_t q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [19:0] mk(input logic [5:0] h, input logic [6:0] m, input logic [6:0] s);
    return {h, m, s};
  endfunction

  task automatic expect_ev(input logic f, input int c, input logic [19:0] t, input logic [1:0] st);
    ev_t e;
    e.is_ferr = f;
    e.cyc     = c;
    e.t       = t;
    e.st      = st;
    q.push_back(e);
  endtask

  task automatic check_ev(input logic f);
    ev_t e;
    chk(f ? "ferr_expected" : "pps_expected", (q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("ev_kind", {31'd0, f}, {31'd0, e.is_ferr});
      chk("ev_cycle", cyc, e.cyc);
      chk("ev_loc", {12'd0, loc_hour, loc_min, loc_sec}, {12'd0, e.t});
      chk("ev_state", {30'd0, state}, {30'd0, e.st});
    end
  endtask

  // Monitor: every pps / frame_err pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (pps === 1'b1) check_ev(1'b0);
    if (frame_err === 1'b1) check_ev(1'b1);
  end

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic send(input logic [19:0] t);
    time_flag = 1'b1;
    {hour_bcd, min_bcd, sec_bcd} = t;
    @(negedge clk);
    time_flag = 1'b0;
  endtask

  task automatic chk_state(input string nm, input logic [1:0] exp);
    chk(nm, {30'd0, state}, {30'd0, exp});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, k2, k3, k4;
    rst       = 1'b1;
    time_flag = 1'b0;
    sec_bcd   = '0;
    min_bcd   = '0;
    hour_bcd  = '0;
    repeat (3) @(negedge clk);
    chk_state("rst_state", 2'b00);
    chk("rst_pps", {31'd0, pps}, 32'd0);
    chk("rst_loc", {12'd0, loc_hour, loc_min, loc_sec}, 32'd0);
    chk("rst_flags", {29'd0, locked, time_valid, frame_err}, 32'd0);
    rst = 1'b0;

    // Acquire and lock on 12:34:56, :57, :58.
    k = cyc + 5;
    wait_to(k);
    send(mk(6'h12, 7'h34, 7'h56));
    chk_state("acq_after_f1", 2'b01);
    wait_to(k + 1000);
    send(mk(6'h12, 7'h34, 7'h57));
    chk_state("acq_after_f2", 2'b01);
    expect_ev(1'b0, k + 2001, mk(6'h12, 7'h34, 7'h59), 2'b10);
    wait_to(k + 2000);
    send(mk(6'h12, 7'h34, 7'h58));
    chk_state("locked_after_f3", 2'b10);
    chk("locked_flags", {30'd0, locked, time_valid}, 32'd3);

    // Continuous frames while locked, one of them 5 cycles early.
    expect_ev(1'b0, k + 3001, mk(6'h12, 7'h35, 7'h00), 2'b10);
    wait_to(k + 3000);
    send(mk(6'h12, 7'h34, 7'h59));
    expect_ev(1'b0, k + 4001, mk(6'h12, 7'h35, 7'h01), 2'b10);
    wait_to(k + 4000);
    send(mk(6'h12, 7'h35, 7'h00));
    expect_ev(1'b0, k + 4996, mk(6'h12, 7'h35, 7'h02), 2'b10);
    expect_ev(1'b0, k + 5996, mk(6'h12, 7'h35, 7'h03), 2'b10);
    wait_to(k + 4995);
    send(mk(6'h12, 7'h35, 7'h01));
    wait_to(k + 6000);
    send(mk(6'h12, 7'h35, 7'h02));
    chk_state("late_frame_keeps_lock", 2'b10);
    expect_ev(1'b0, k + 7001, mk(6'h12, 7'h35, 7'h04), 2'b10);
    wait_to(k + 7000);
    send(mk(6'h12, 7'h35, 7'h03));

    // Frames stop: holdover, free-running pps, then loss after 4 wraps.
    expect_ev(1'b0, k + 8001,  mk(6'h12, 7'h35, 7'h05), 2'b10);
    expect_ev(1'b0, k + 9001,  mk(6'h12, 7'h35, 7'h06), 2'b11);
    expect_ev(1'b0, k + 10001, mk(6'h12, 7'h35, 7'h07), 2'b11);
    expect_ev(1'b0, k + 11001, mk(6'h12, 7'h35, 7'h08), 2'b11);
    expect_ev(1'b0, k + 12001, mk(6'h12, 7'h35, 7'h09), 2'b11);
    wait_to(k + 8011);
    chk_state("pre_holdover", 2'b10);
    @(negedge clk);
    chk_state("holdover_entry", 2'b11);
    chk("holdover_flags", {30'd0, locked, time_valid}, 32'd1);
    wait_to(k + 12001);
    chk_state("holdover_last", 2'b11);
    @(negedge clk);
    chk_state("holdover_lost", 2'b00);
    chk("lost_flags", {30'd0, locked, time_valid}, 32'd0);
    chk("lost_loc_held", {12'd0, loc_hour, loc_min, loc_sec}, {12'd0, mk(6'h12, 7'h35, 7'h09)});
    wait_to(k + 13500);

    // Midnight rollover, then re-lock from holdover with a late frame.
    k2 = cyc;
    send(mk(6'h23, 7'h59, 7'h55));
    wait_to(k2 + 1000);
    send(mk(6'h23, 7'h59, 7'h56));
    expect_ev(1'b0, k2 + 2001, mk(6'h23, 7'h59, 7'h58), 2'b10);
    expect_ev(1'b0, k2 + 3001, mk(6'h23, 7'h59, 7'h59), 2'b10);
    expect_ev(1'b0, k2 + 4001, mk(6'h00, 7'h00, 7'h00), 2'b11);
    wait_to(k2 + 2000);
    send(mk(6'h23, 7'h59, 7'h57));
    wait_to(k2 + 3012);
    chk_state("midnight_holdover", 2'b11);
    wait_to(k2 + 4003);
    send(mk(6'h23, 7'h59, 7'h59));
    chk_state("relock_from_holdover", 2'b10);

    // Illegal frame while locked: frame_err only.
    expect_ev(1'b1, k2 + 4501, mk(6'h00, 7'h00, 7'h00), 2'b10);
    expect_ev(1'b0, k2 + 5004, mk(6'h00, 7'h00, 7'h01), 2'b10);
    wait_to(k2 + 4500);
    send(mk(6'h00, 7'h00, 7'h0A));
    chk_state("illegal_keeps_lock", 2'b10);

    // One-cycle reset while running clears everything; no further pps.
    wait_to(k2 + 5500);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_state("midrst_state", 2'b00);
    chk("midrst_loc", {12'd0, loc_hour, loc_min, loc_sec}, 32'd0);
    chk("midrst_flags", {28'd0, pps, locked, time_valid, frame_err}, 32'd0);
    wait_to(k2 + 6500);

    // Illegal frame during acquisition drops back to unlocked.
    k3 = cyc;
    send(mk(6'h01, 7'h02, 7'h03));
    chk_state("acq2_start", 2'b01);
    wait_to(k3 + 1000);
    send(mk(6'h01, 7'h02, 7'h0A));
    chk_state("acq_illegal_unlock", 2'b00);

    // Missing frame after a wrap during acquisition times out.
    k4 = k3 + 1500;
    wait_to(k4);
    send(mk(6'h01, 7'h02, 7'h04));
    wait_to(k4 + 1012);
    chk_state("acq_timeout_edge", 2'b01);
    @(negedge clk);
    chk_state("acq_timeout", 2'b00);

    wait_to(k4 + 1100);
    chk("sb_drained", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
